// File: rtl/mixer_pwm_dac.sv
// Mixes CHANNELS voice samples with per-channel volume via a serial MAC FSM and drives a 1-bit
// audio pin with frame-synchronous PWM or a first-order sigma-delta modulator.
module mixer_pwm_dac #(
  parameter int CHANNELS = 4,
  parameter int SW       = 4,
  parameter int VW       = 2,
  parameter int OW       = 6,
  parameter int SHIFT    = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sample_ena,
  input  logic [CHANNELS*SW-1:0] samples,
  input  logic [CHANNELS*VW-1:0] volumes,
  input  logic                   pwm_ena,
  input  logic                   mode,
  output logic [OW-1:0]          mix_out,
  output logic                   mix_valid,
  output logic                   busy,
  output logic                   overrun,
  output logic                   pwm
);

  localparam int AW   = SW + VW + $clog2(CHANNELS) + (((CHANNELS & (CHANNELS - 1)) == 0) ? 1 : 0);
  localparam int IW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int MW   = AW + OW;
  localparam int MAXV = (1 << OW) - 1;

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_t;

  state_t                       state, state_nxt;
  logic [CHANNELS-1:0][SW-1:0]  sh_s;
  logic [CHANNELS-1:0][VW-1:0]  sh_v;
  logic [IW-1:0]                idx;
  logic [AW-1:0]                acc;
  logic [SW+VW-1:0]             prod;
  logic [MW-1:0]                m_w;
  logic [OW-1:0]                m_sat;

  assign prod  = (SW+VW)'(sh_s[idx]) * (SW+VW)'(sh_v[idx]);
  // widened so the saturation compare is valid even when AW < OW
  assign m_w   = MW'(acc) >> SHIFT;
  assign m_sat = (m_w > MW'(MAXV)) ? OW'(MAXV) : m_w[OW-1:0];
  assign busy  = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_ena) state_nxt = ACCUM;
      ACCUM:   if (idx == IW'(CHANNELS - 1)) state_nxt = SCALE;
      SCALE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      sh_s      <= '0;
      sh_v      <= '0;
      idx       <= '0;
      acc       <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      mix_valid <= 1'b0;
      overrun   <= sample_ena && (state != IDLE);
      case (state)
        IDLE: if (sample_ena) begin
          sh_s <= samples;
          sh_v <= volumes;
          acc  <= '0;
          idx  <= '0;
        end
        ACCUM: begin
          acc <= acc + AW'(prod);
          idx <= idx + 1'b1;
        end
        SCALE: begin
          mix_out   <= m_sat;
          mix_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  logic [OW-1:0] cnt, sd, level;
  logic          mode_q;
  logic [OW:0]   sd_sum;

  assign sd_sum = {1'b0, sd} + {1'b0, level};

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= '0;
      sd     <= '0;
      level  <= '0;
      mode_q <= 1'b0;
      pwm    <= 1'b0;
    end else begin
      if (mode_q && mix_valid) level <= mix_out;
      if (pwm_ena) begin
        if (!mode_q) begin
          pwm <= (cnt < level);
          cnt <= cnt + 1'b1;
          // frame boundary: only here may level/mode change, so frames are never torn
          if (cnt == OW'(MAXV)) begin
            level  <= mix_out;
            mode_q <= mode;
            if (mode) sd <= '0;
          end
        end else begin
          pwm <= sd_sum[OW];
          sd  <= sd_sum[OW-1:0];
          if (sd_sum[OW] || level == '0) begin
            mode_q <= mode;
            if (!mode) cnt <= '0;
          end
        end
      end
    end
  end

endmodule
